// File: rtl/fb_scanout_pkg.sv
// Shared VGA / framebuffer definitions: 640x480@60 timing, framebuffer geometry,
// RGB565 field layout (also used by the render blocks) and the pixel-slot phase type.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned FB_W  = H_ACTIVE;
  localparam int unsigned FB_H  = V_ACTIVE;
  localparam int unsigned FB_AW = 19;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef logic [15:0] rgb565_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Four clk per pixel slot; names describe what happens on the edge ending each phase.
  typedef enum logic [1:0] {
    PH_ISSUE  = 2'd0,
    PH_STROBE = 2'd1,
    PH_DATA   = 2'd2,
    PH_PIX    = 2'd3
  } phase_e;

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer RAM read port: scanout drives address/strobe, RAM returns data one clk later.
interface fb_scanout_if;
  import vga_pkg::*;

  logic [FB_AW-1:0] src_addr;
  logic             src_rd;
  rgb565_t          src_data;

  modport master (output src_addr, output src_rd, input src_data);
  modport slave  (input src_addr, input src_rd, output src_data);
endinterface

// File: rtl/fb_scanout_timing.sv
// VGA raster timing: pixel-slot phase plus horizontal/vertical counters, with decoded
// active/sync/blank/wrap flags for the current counter position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS    = H_ACTIVE,
  parameter int unsigned H_FPORCH = H_FP,
  parameter int unsigned H_SYNCW  = H_SYNC,
  parameter int unsigned H_BPORCH = H_BP,
  parameter int unsigned V_VIS    = V_ACTIVE,
  parameter int unsigned V_FPORCH = V_FP,
  parameter int unsigned V_SYNCW  = V_SYNC,
  parameter int unsigned V_BPORCH = V_BP
) (
  input  logic   clk,
  input  logic   rstn,
  output phase_e phase_o,
  output logic   pix_en_o,
  output logic   active_o,
  output logic   hs_raw_o,
  output logic   vs_raw_o,
  output logic   vblank_raw_o,
  output logic   frame_wrap_o
);

  localparam int unsigned H_TOT = H_VIS + H_FPORCH + H_SYNCW + H_BPORCH;
  localparam int unsigned V_TOT = V_VIS + V_FPORCH + V_SYNCW + V_BPORCH;
  localparam int unsigned HW    = $clog2(H_TOT + 1);
  localparam int unsigned VW    = $clog2(V_TOT + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FPORCH);
  localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FPORCH + H_SYNCW);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FPORCH);
  localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FPORCH + V_SYNCW);

  phase_e          phase_q, phase_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= PH_ISSUE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    case (phase_q)
      PH_ISSUE:  phase_d = PH_STROBE;
      PH_STROBE: phase_d = PH_DATA;
      PH_DATA:   phase_d = PH_PIX;
      PH_PIX: begin
        phase_d = PH_ISSUE;
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default:   phase_d = PH_ISSUE;
    endcase
  end

  always_comb begin
    phase_o      = phase_q;
    pix_en_o     = (phase_q == PH_PIX);
    active_o     = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
    hs_raw_o     = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_raw_o     = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    vblank_raw_o = (vcnt_q >= V_VIS_C);
    frame_wrap_o = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: one RAM read per visible pixel at 25 MHz pixel rate, RGB565 to
// 12-bit colour, with sync/blank registered in the same slot as the colour they frame.
module fb_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_VIS    = H_ACTIVE,
  parameter int unsigned H_FPORCH = H_FP,
  parameter int unsigned H_SYNCW  = H_SYNC,
  parameter int unsigned H_BPORCH = H_BP,
  parameter int unsigned V_VIS    = V_ACTIVE,
  parameter int unsigned V_FPORCH = V_FP,
  parameter int unsigned V_SYNCW  = V_SYNC,
  parameter int unsigned V_BPORCH = V_BP
) (
  input  logic         clk,
  input  logic         rstn,
  fb_scanout_if.master src,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         vblank,
  output logic         frame_start
);

  phase_e phase;
  logic   pix_en, active, hs_raw, vs_raw, vblank_raw, frame_wrap;

  vga_timing #(
    .H_VIS    (H_VIS),
    .H_FPORCH (H_FPORCH),
    .H_SYNCW  (H_SYNCW),
    .H_BPORCH (H_BPORCH),
    .V_VIS    (V_VIS),
    .V_FPORCH (V_FPORCH),
    .V_SYNCW  (V_SYNCW),
    .V_BPORCH (V_BPORCH)
  ) u_timing (
    .clk          (clk),
    .rstn         (rstn),
    .phase_o      (phase),
    .pix_en_o     (pix_en),
    .active_o     (active),
    .hs_raw_o     (hs_raw),
    .vs_raw_o     (vs_raw),
    .vblank_raw_o (vblank_raw),
    .frame_wrap_o (frame_wrap)
  );

  logic [FB_AW-1:0] addr_q, addr_d;
  logic [FB_AW-1:0] src_addr_q, src_addr_d;
  logic             src_rd_q, src_rd_d;
  rgb444_t          pix_q, pix_d;
  rgb444_t          rgb_q, rgb_d;
  logic             hs_q, hs_d, vs_q, vs_d, vblank_q, vblank_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q     <= '0;
      src_addr_q <= '0;
      src_rd_q   <= 1'b0;
      pix_q      <= '0;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      vblank_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      src_addr_q <= src_addr_d;
      src_rd_q   <= src_rd_d;
      pix_q      <= pix_d;
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      vblank_q   <= vblank_d;
    end
  end

  // The strobe is registered out of PH_ISSUE, so the RAM answers during PH_DATA and
  // the word is captured on the edge ending that phase.
  always_comb begin
    addr_d     = addr_q;
    src_addr_d = src_addr_q;
    src_rd_d   = 1'b0;
    pix_d      = pix_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    vblank_d   = vblank_q;
    if ((phase == PH_ISSUE) && active) begin
      src_rd_d   = 1'b1;
      src_addr_d = addr_q;
      addr_d     = addr_q + 1'b1;
    end
    if (phase == PH_DATA) begin
      pix_d = '{r: src.src_data[R_MSB -: 4],
                g: src.src_data[G_MSB -: 4],
                b: src.src_data[B_MSB -: 4]};
    end
    if (pix_en) begin
      hs_d     = hs_raw;
      vs_d     = vs_raw;
      vblank_d = vblank_raw;
      rgb_d    = active ? pix_q : '0;
      if (frame_wrap) addr_d = '0;
    end
  end

  assign src.src_addr = src_addr_q;
  assign src.src_rd   = src_rd_q;
  assign vga_hs       = hs_q;
  assign vga_vs       = vs_q;
  assign vga_r        = rgb_q.r;
  assign vga_g        = rgb_q.g;
  assign vga_b        = rgb_q.b;
  assign vblank       = vblank_q;
  assign frame_start  = pix_en & frame_wrap;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: one full-size instance (first lines of a frame) and one shrunken
// raster (whole frames), both compared against a closed-form raster model every clk.
module tb_fb_scanout;

  localparam int S_HA = 16, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FRAME = 4 * S_HT * S_VT;

  typedef struct packed { int ha, hf, hs, hb, va, vf, vs, vb; } geom_t;
  localparam geom_t GD = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33};
  localparam geom_t GS = '{ha:S_HA, hf:S_HF, hs:S_HS, hb:S_HB,
                           va:S_VA, vf:S_VF, vs:S_VS, vb:S_VB};

  // {src_rd, src_addr, hs, vs, r, g, b, vblank, frame_start}
  typedef logic [35:0] obs_t;
  localparam obs_t RST_OBS = {1'b0, 19'd0, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rstn;
  int   compared = 0;
  int   mismatched = 0;
  bit   mode = 1'b0;
  logic [15:0] key = '0;

  always #5 clk = ~clk;

  fb_scanout_if bus0 ();
  fb_scanout_if bus1 ();
  logic hs0, vs0, vb0, fs0, hs1, vs1, vb1, fs1;
  logic [3:0] r0, g0, b0, r1, g1, b1;

  fb_scanout u_dflt (
    .clk (clk), .rstn (rstn), .src (bus0),
    .vga_hs (hs0), .vga_vs (vs0), .vga_r (r0), .vga_g (g0), .vga_b (b0),
    .vblank (vb0), .frame_start (fs0)
  );

  fb_scanout #(
    .H_VIS (S_HA), .H_FPORCH (S_HF), .H_SYNCW (S_HS), .H_BPORCH (S_HB),
    .V_VIS (S_VA), .V_FPORCH (S_VF), .V_SYNCW (S_VS), .V_BPORCH (S_VB)
  ) u_small (
    .clk (clk), .rstn (rstn), .src (bus1),
    .vga_hs (hs1), .vga_vs (vs1), .vga_r (r1), .vga_g (g1), .vga_b (b1),
    .vblank (vb1), .frame_start (fs1)
  );

  function automatic logic [15:0] mem_word(input int a);
    return mode ? 16'hFFFF : (a[15:0] ^ key);
  endfunction

  // Synchronous RAM: data valid the clk after a strobe, noise otherwise.
  always @(posedge clk) begin
    bus0.src_data <= bus0.src_rd ? mem_word(int'(bus0.src_addr)) : (mode ? 16'hFFFF : 16'($urandom));
    bus1.src_data <= bus1.src_rd ? mem_word(int'(bus1.src_addr)) : (mode ? 16'hFFFF : 16'($urandom));
  end

  // Expected outputs after the n-th clk edge following reset release.
  function automatic obs_t model(input geom_t g, input int n);
    int ht, vt, k, h, v, a;
    logic rd, hs, vs, vb, fs;
    logic [11:0] rgb;
    logic [15:0] d;
    ht = g.ha + g.hf + g.hs + g.hb;
    vt = g.va + g.vf + g.vs + g.vb;
    k = n / 4; h = k % ht; v = (k / ht) % vt;
    rd = (n % 4 == 0) && (h < g.ha) && (v < g.va);
    a  = rd ? v * g.ha + h : 0;
    fs = (n % 4 == 2) && (h == ht - 1) && (v == vt - 1);
    hs = 1'b1; vs = 1'b1; vb = 1'b0; rgb = '0;
    if (n >= 3) begin
      k = (n - 3) / 4; h = k % ht; v = (k / ht) % vt;
      hs = !((h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs));
      vs = !((v >= g.va + g.vf) && (v < g.va + g.vf + g.vs));
      vb = (v >= g.va);
      if ((h < g.ha) && (v < g.va)) begin
        d = mem_word(v * g.ha + h);
        rgb = {d[15:12], d[10:7], d[4:1]};
      end
    end
    return {rd, a[18:0], hs, vs, rgb, vb, fs};
  endfunction

  function automatic obs_t obs_d(input logic rd_exp);
    return {bus0.src_rd, rd_exp ? bus0.src_addr : 19'd0, hs0, vs0, r0, g0, b0, vb0, fs0};
  endfunction

  function automatic obs_t obs_s(input logic rd_exp);
    return {bus1.src_rd, rd_exp ? bus1.src_addr : 19'd0, hs1, vs1, r1, g1, b1, vb1, fs1};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (obs_d(1'b1) !== RST_OBS) begin
      mismatched++; $display("FAIL reset_dflt got %h want %h", obs_d(1'b1), RST_OBS);
    end
    compared++;
    if (obs_s(1'b1) !== RST_OBS) begin
      mismatched++; $display("FAIL reset_small got %h want %h", obs_s(1'b1), RST_OBS);
    end
  endtask

  task automatic test_scan_default();
    obs_t e, o;
    int rd_l0 = 0, rd_blank = 0, hs_low = 0, hs_first = -1;
    mode = 1'b0; key = '0;
    do_reset();
    for (int n = 0; n < 4 * 1610; n++) begin
      @(negedge clk);
      e = model(GD, n); o = obs_d(e[35]);
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL scan_dflt n=%0d got %h want %h", n, o, e); end
      if (n < 3200) begin
        rd_l0 += int'(bus0.src_rd);
        if (n >= 2560) rd_blank += int'(bus0.src_rd);
        if (!hs0) begin hs_low++; if (hs_first < 0) hs_first = n; end
      end
      if (n == 3200) begin
        compared++;
        if ({bus0.src_rd, bus0.src_addr} !== {1'b1, 19'd640}) begin
          mismatched++; $display("FAIL line1_start got rd=%b addr=%0d want rd=1 addr=640", bus0.src_rd, bus0.src_addr);
        end
      end
      if (n == 3207) begin
        compared++;
        if ({r0, g0, b0} !== 12'h050) begin
          mismatched++; $display("FAIL pixel641 got %h want 050", {r0, g0, b0});
        end
      end
    end
    compared++;
    if (rd_l0 !== 640) begin mismatched++; $display("FAIL reads_line0 got %0d want 640", rd_l0); end
    compared++;
    if (rd_blank !== 0) begin mismatched++; $display("FAIL reads_hblank got %0d want 0", rd_blank); end
    compared++;
    if (hs_low !== 384) begin mismatched++; $display("FAIL hs_width got %0d want 384", hs_low); end
    compared++;
    if (hs_first !== 2627) begin mismatched++; $display("FAIL hs_start got %0d want 2627", hs_first); end
  endtask

  task automatic test_frame_small();
    obs_t e, o;
    int reads = 0, max_a = -1, vs_low = 0;
    int fs_n[$];
    bit pending = 1'b0;
    mode = 1'b0; key = 16'($urandom);
    do_reset();
    for (int n = 0; n < 2 * S_FRAME + 40; n++) begin
      @(negedge clk);
      e = model(GS, n); o = obs_s(e[35]);
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL frame_small n=%0d got %h want %h", n, o, e); end
      if (n < S_FRAME) begin
        if (bus1.src_rd) begin reads++; if (int'(bus1.src_addr) > max_a) max_a = int'(bus1.src_addr); end
        if (!vs1) vs_low++;
      end
      if (fs1) begin
        fs_n.push_back(n); pending = 1'b1;
      end else if (pending && bus1.src_rd) begin
        pending = 1'b0;
        compared++;
        if (bus1.src_addr !== 19'd0) begin
          mismatched++; $display("FAIL addr_after_fs got %0d want 0", bus1.src_addr);
        end
      end
    end
    compared++;
    if (reads !== S_HA * S_VA) begin mismatched++; $display("FAIL reads_frame got %0d want %0d", reads, S_HA * S_VA); end
    compared++;
    if (max_a !== S_HA * S_VA - 1) begin mismatched++; $display("FAIL last_addr got %0d want %0d", max_a, S_HA * S_VA - 1); end
    compared++;
    if (vs_low !== 4 * S_HT * S_VS) begin mismatched++; $display("FAIL vs_width got %0d want %0d", vs_low, 4 * S_HT * S_VS); end
    compared++;
    if (fs_n.size() !== 2) begin
      mismatched++; $display("FAIL fs_count got %0d want 2", fs_n.size());
    end else begin
      compared++;
      if (fs_n[1] - fs_n[0] !== S_FRAME) begin
        mismatched++; $display("FAIL fs_period got %0d want %0d", fs_n[1] - fs_n[0], S_FRAME);
      end
    end
  endtask

  task automatic test_blanking();
    obs_t e, o;
    int white = 0;
    mode = 1'b1;
    do_reset();
    for (int n = 0; n < S_FRAME + 8; n++) begin
      @(negedge clk);
      e = model(GS, n); o = obs_s(e[35]);
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL blanking n=%0d got %h want %h", n, o, e); end
      if ((n >= 3) && (n < S_FRAME + 3) && ({r1, g1, b1} == 12'hFFF)) white++;
    end
    compared++;
    if (white !== 4 * S_HA * S_VA) begin mismatched++; $display("FAIL white_cycles got %0d want %0d", white, 4 * S_HA * S_VA); end
  endtask

  task automatic test_midframe_reset();
    obs_t e, o;
    int line, pix, n_stop, vs_first = -1;
    mode = 1'b0; key = 16'($urandom);
    line = $urandom_range(S_VA - 1, 1);
    pix = $urandom_range(S_HA - 1, 1);
    n_stop = 4 * (line * S_HT + pix) + $urandom_range(3, 0);
    do_reset();
    for (int n = 0; n <= n_stop; n++) begin
      @(negedge clk);
      e = model(GS, n); o = obs_s(e[35]);
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL pre_reset n=%0d got %h want %h", n, o, e); end
    end
    #2 rstn = 1'b0;
    #1;
    compared++;
    if (obs_s(1'b1) !== RST_OBS) begin mismatched++; $display("FAIL async_rst_small got %h want %h", obs_s(1'b1), RST_OBS); end
    compared++;
    if (obs_d(1'b1) !== RST_OBS) begin mismatched++; $display("FAIL async_rst_dflt got %h want %h", obs_d(1'b1), RST_OBS); end
    @(negedge clk);
    rstn = 1'b1;
    for (int n = 0; n < S_FRAME + 8; n++) begin
      @(negedge clk);
      e = model(GS, n); o = obs_s(e[35]);
      compared++;
      if (o !== e) begin mismatched++; $display("FAIL post_reset n=%0d got %h want %h", n, o, e); end
      if (!vs1 && (vs_first < 0)) vs_first = n;
    end
    compared++;
    if (vs_first !== 4 * S_HT * (S_VA + S_VF) + 3) begin
      mismatched++; $display("FAIL vs_first got %0d want %0d", vs_first, 4 * S_HT * (S_VA + S_VF) + 3);
    end
  endtask

  initial begin
    rstn = 1'b1;
    #2 rstn = 1'b0;
    test_reset();
    test_scan_default();
    test_frame_small();
    test_blanking();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
